make_next_reg: RTL and testbench
================================

// Module: make_next_reg
// PURPOSE
//   Next-state engine of the 8-bit accumulator CPU: fetches/decodes the instruction at ip from the
//   flat memory image and produces every register's next value plus a single-byte memory write
//   request. The parent latches next_* and performs the write on the same CLOCK edge.
//   Instruction execution is combinational. The only internal state is a halted flag.
// PARAMETERS
//   MEMSIZE  64  bytes of memory; fetch/data addresses are taken modulo MEMSIZE; sp reset value
// PORTS
//   CLOCK        in   1          single clock, rising edge
//   RESET        in   1          asynchronous, active-high
//   memory       in   8xMEMSIZE  unpacked memory image (read-only here)
//   write_flag   out  1          1 = write write_value to memory[write_addr] this edge
//   write_addr   out  MEMSIZE    byte address, zero-extended, < MEMSIZE
//   write_value  out  8          data to write
//   a,b,c,d,sp,ip in  8 each     current registers; zf in 1
//   next_a..next_ip out 8 each   next registers; next_zf out 1
//   halted       out  1          registered: hlt has executed
// BEHAVIOUR
//   Fetch: op=memory[ip%MEMSIZE], imm=memory[(ip+1)%MEMSIZE]. dst=op[3:2], src=op[1:0].
//   Register codes: 00=a, 01=b, 10=c, 11=d.
//   op[7]=0 is ALU. op[6]=1 uses imm as the operand (2 bytes, ip+=2); otherwise reg[src] (1 byte, ip+=1).
//     op[5:4]=00 mov: dst<=operand, zf unchanged.
//     op[5:4]=01 add: dst<=dst+operand mod 256, zf<=(result==0).
//     op[5:4]=10 sub: dst<=dst-operand mod 256, zf<=(result==0).
//     op[5:4]=11 cmp: zf<=((dst-operand)==0), no register written.
//   op[7]=1 is decoded by op[6:4]:
//     000 ld:   dst<=memory[imm%MS]; ip+=2.
//     001 st:   write [imm%MS]<=reg[dst]; ip+=2.
//     010 push: sp<=sp-1; write [(sp-1)%MS]<=reg[dst]; ip+=1.
//     011 pop:  dst<=memory[sp%MS]; sp<=sp+1; ip+=1.
//     100 jmp:  ip<=ip+2+imm (imm signed).
//     101 jz:   same as jmp if zf=1, else ip+=2.
//     110 jnz:  same as jmp if zf=0, else ip+=2.
//     111 hlt:  all next_*=current; ip holds; halted<=1 on the next CLOCK edge.
//   op[1:0] is ignored for the ld/st/push/pop/jump/hlt forms.
//   Arithmetic is 8-bit wrap. Example: ip=15 with jnz imm=0xF7 gives target 8. ip wraps 255->0.
//   Registers not written by an instruction pass through unchanged.
//   write_flag=0 except for st/push. write_addr/value are 0 when write_flag=0.
//   While halted=1: next_*=current, write_flag=0 (CPU frozen until RESET).
//   RESET high:
//     halted clears immediately (async).
//     write_flag=0.
//     next_a..d=0, next_sp=MEMSIZE, next_ip=0, next_zf=0.
//   RESET deassert: normal decode resumes from the incoming register values.
//   Simultaneous: push/pop at sp=0 or sp=MEMSIZE address modulo MEMSIZE.
//   Simultaneous: pop into the sp register is not encodable (dst is a..d only).
// STRUCTURE
//   Package cpu_pkg:
//     MEMSIZE default
//     reg_e enum {A,B,C,D}
//     ALU op codes {MOV,ADD,SUB,CMP}
//     OP_LD..OP_HLT constants
//   One sub-module: make_next_reg_alu, combinational. Takes dst, operand and alu op; returns
//   result, write-enable and zf. The top level holds decode, memory/stack/jump logic and the
//   halted flop.
// TESTING
//   Fibonacci image, run to hlt:
//     image = 40 01 44 01 48 00 4C 01 09 04 12 5C 01 7C 09 E0 F7 F0
//     -> a=55, b=34, c=21, d=9, zf=1, ip=17, halted=1
//   mov b,imm 0xFF then add b,imm 1 -> next_b=0x00, next_zf=1; a mov after it leaves zf=1
//   sp=64, a=0xA5, push a (0xA0) -> write_flag=1, write_addr=63, write_value=0xA5, next_sp=63;
//     then pop c (0xB8) -> next_c=0xA5, next_sp=64
//   st [0x30],d (0x9C 0x30) with d=7 -> write 7 at addr 48; ld a,[0x30] (0x80 0x30) -> next_a=7
//   jz at ip=20 with imm=0xF0: zf=1 -> next_ip=6; zf=0 -> next_ip=22
//   RESET mid-run while halted=1 -> halted=0 at once, write_flag=0, next_sp=64, next_ip=0

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cpu_pkg : register codes, ALU ops and opcode groups of the 8-bit accumulator CPU
// Revision: 1.0
// ----------------------------------------------------------------------------
package cpu_pkg;

  localparam int MEMSIZE_DEFAULT = 64;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_C = 2'd2,
    REG_D = 2'd3
  } reg_e;

  typedef enum logic [1:0] {
    ALU_MOV = 2'd0,
    ALU_ADD = 2'd1,
    ALU_SUB = 2'd2,
    ALU_CMP = 2'd3
  } alu_op_e;

  // op[6:4] decode when op[7]=1
  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_PUSH = 3'd2;
  localparam logic [2:0] OP_POP  = 3'd3;
  localparam logic [2:0] OP_JMP  = 3'd4;
  localparam logic [2:0] OP_JZ   = 3'd5;
  localparam logic [2:0] OP_JNZ  = 3'd6;
  localparam logic [2:0] OP_HLT  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/make_next_reg_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// make_next_reg_alu : combinational mov/add/sub/cmp with zero-flag generation
// Revision: 1.0
// ----------------------------------------------------------------------------
module make_next_reg_alu
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [7:0] dst_val,
  input  logic [7:0] operand,
  input  logic       zf_in,
  output logic [7:0] result,
  output logic       we,
  output logic       zf_out
);

  logic [7:0] sum;
  logic [7:0] diff;

  always_comb begin
    sum    = dst_val + operand;
    diff   = dst_val - operand;
    result = operand;
    we     = 1'b0;
    zf_out = zf_in;
    case (alu_op_e'(alu_op))
      ALU_MOV: begin
        result = operand;
        we     = 1'b1;
      end
      ALU_ADD: begin
        result = sum;
        we     = 1'b1;
        zf_out = (sum == 8'h00);
      end
      ALU_SUB: begin
        result = diff;
        we     = 1'b1;
        zf_out = (diff == 8'h00);
      end
      ALU_CMP: begin
        // flags only; the destination register is left alone
        zf_out = (diff == 8'h00);
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/make_next_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// make_next_reg : fetch/decode/execute next-state engine of the accumulator CPU
// Revision: 1.0
// ----------------------------------------------------------------------------
module make_next_reg
  import cpu_pkg::*;
#(
  parameter int MEMSIZE = MEMSIZE_DEFAULT
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [7:0]         memory [MEMSIZE],
  output logic               write_flag,
  output logic [MEMSIZE-1:0] write_addr,
  output logic [7:0]         write_value,
  input  logic [7:0]         a,
  input  logic [7:0]         b,
  input  logic [7:0]         c,
  input  logic [7:0]         d,
  input  logic [7:0]         sp,
  input  logic [7:0]         ip,
  input  logic               zf,
  output logic [7:0]         next_a,
  output logic [7:0]         next_b,
  output logic [7:0]         next_c,
  output logic [7:0]         next_d,
  output logic [7:0]         next_sp,
  output logic [7:0]         next_ip,
  output logic               next_zf,
  output logic               halted
);

  localparam int         AW       = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
  localparam logic [7:0] SP_RESET = 8'(MEMSIZE);

  function automatic logic [AW-1:0] to_idx(input logic [7:0] addr);
    return AW'(32'(addr) % MEMSIZE);
  endfunction

  logic          halted_q;
  logic          halted_d;
  logic [7:0]    op;
  logic [7:0]    imm;
  logic [7:0]    operand;
  logic [7:0]    jump_target;
  reg_e          dst;
  reg_e          src;
  logic [7:0]    regs  [4];
  logic [7:0]    nregs [4];
  logic [7:0]    alu_result;
  logic          alu_we;
  logic          alu_zf;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_val;
  logic [7:0]    nsp;
  logic [7:0]    nip;
  logic          nzf;

  assign regs[0] = a;
  assign regs[1] = b;
  assign regs[2] = c;
  assign regs[3] = d;

  assign op          = memory[to_idx(ip)];
  assign imm         = memory[to_idx(ip + 8'd1)];
  assign dst         = reg_e'(op[3:2]);
  assign src         = reg_e'(op[1:0]);
  assign operand     = op[6] ? imm : regs[src];
  assign jump_target = ip + 8'd2 + imm;

  make_next_reg_alu u_alu (
    .alu_op  (op[5:4]),
    .dst_val (regs[dst]),
    .operand (operand),
    .zf_in   (zf),
    .result  (alu_result),
    .we      (alu_we),
    .zf_out  (alu_zf)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) nregs[i] = regs[i];
    nsp      = sp;
    nip      = ip;
    nzf      = zf;
    wr_en    = 1'b0;
    wr_idx   = '0;
    wr_val   = 8'h00;
    halted_d = halted_q;

    if (!halted_q) begin
      if (!op[7]) begin
        nip = ip + (op[6] ? 8'd2 : 8'd1);
        nzf = alu_zf;
        if (alu_we) nregs[dst] = alu_result;
      end else begin
        case (op[6:4])
          OP_LD: begin
            nregs[dst] = memory[to_idx(imm)];
            nip        = ip + 8'd2;
          end
          OP_ST: begin
            wr_en  = 1'b1;
            wr_idx = to_idx(imm);
            wr_val = regs[dst];
            nip    = ip + 8'd2;
          end
          OP_PUSH: begin
            nsp    = sp - 8'd1;
            wr_en  = 1'b1;
            wr_idx = to_idx(sp - 8'd1);
            wr_val = regs[dst];
            nip    = ip + 8'd1;
          end
          OP_POP: begin
            nregs[dst] = memory[to_idx(sp)];
            nsp        = sp + 8'd1;
            nip        = ip + 8'd1;
          end
          OP_JMP:  nip = jump_target;
          OP_JZ:   nip = zf ? jump_target : ip + 8'd2;
          OP_JNZ:  nip = zf ? ip + 8'd2 : jump_target;
          OP_HLT:  halted_d = 1'b1;
          default: ;
        endcase
      end
    end

    // Reset forces the architectural power-on values onto the next_* bus.
    if (RESET) begin
      for (int i = 0; i < 4; i++) nregs[i] = 8'h00;
      nsp    = SP_RESET;
      nip    = 8'h00;
      nzf    = 1'b0;
      wr_en  = 1'b0;
      wr_idx = '0;
      wr_val = 8'h00;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end

  assign next_a      = nregs[0];
  assign next_b      = nregs[1];
  assign next_c      = nregs[2];
  assign next_d      = nregs[3];
  assign next_sp     = nsp;
  assign next_ip     = nip;
  assign next_zf     = nzf;
  assign write_flag  = wr_en;
  assign write_addr  = {{(MEMSIZE-AW){1'b0}}, wr_idx};
  assign write_value = wr_val;
  assign halted      = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_make_next_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_make_next_reg : directed vector table plus multi-cycle sequences for make_next_reg
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_make_next_reg;

  localparam int MS = 64;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic [7:0]    mem [MS];
  logic          write_flag;
  logic [MS-1:0] write_addr;
  logic [7:0]    write_value;
  logic [7:0]    a, b, c, d, sp, ip;
  logic          zf;
  logic [7:0]    next_a, next_b, next_c, next_d, next_sp, next_ip;
  logic          next_zf;
  logic          halted;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK = ~CLOCK;

  make_next_reg #(.MEMSIZE(MS)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .memory(mem),
    .write_flag(write_flag), .write_addr(write_addr), .write_value(write_value),
    .a(a), .b(b), .c(c), .d(d), .sp(sp), .ip(ip), .zf(zf),
    .next_a(next_a), .next_b(next_b), .next_c(next_c), .next_d(next_d),
    .next_sp(next_sp), .next_ip(next_ip), .next_zf(next_zf), .halted(halted)
  );

  typedef struct {
    logic [7:0] ip, op, imm, a, b, c, d, sp;
    logic       zf;
    logic [7:0] daddr, dval;
    logic [7:0] ea, eb, ec, ed, esp, eip;
    logic       ezf, ewf;
    logic [7:0] ewaddr, ewval;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < MS; k++) mem[k] = 8'h00;
  endtask

  task automatic set_regs(input logic [7:0] va, vb, vc, vd, vsp, vip, input logic vzf);
    a = va; b = vb; c = vc; d = vd; sp = vsp; ip = vip; zf = vzf;
  endtask

  // Acts as the parent: sample next_* before the edge, latch them just after it.
  task automatic step();
    logic [7:0] na, nb, nc, nd, nsp, nip, wv;
    logic       nz, wf;
    logic [MS-1:0] wa;
    @(negedge CLOCK);
    na = next_a; nb = next_b; nc = next_c; nd = next_d;
    nsp = next_sp; nip = next_ip; nz = next_zf;
    wf = write_flag; wa = write_addr; wv = write_value;
    @(posedge CLOCK);
    #1;
    set_regs(na, nb, nc, nd, nsp, nip, nz);
    if (wf) mem[wa[5:0]] = wv;
  endtask

  task automatic pulse_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ipn;
    int         n;

    //  ip    op    imm   a     b     c     d     sp   zf daddr dval | ea    eb    ec    ed    esp   eip  ezf ewf waddr wval
    vecs[0]  = '{8'h00,8'h09,8'h00,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h22,8'h44,8'h40,8'h01,1'b0,1'b0,8'h00,8'h00};
    vecs[1]  = '{8'h00,8'h50,8'h10,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h21,8'h22,8'h33,8'h44,8'h40,8'h02,1'b0,1'b0,8'h00,8'h00};
    vecs[2]  = '{8'h04,8'h6C,8'h44,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h00,8'h40,8'h06,1'b1,1'b0,8'h00,8'h00};
    vecs[3]  = '{8'h08,8'h31,8'h00,8'h11,8'h22,8'h33,8'h44,8'h40,1'b1,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h09,1'b0,1'b0,8'h00,8'h00};
    vecs[4]  = '{8'h0C,8'h24,8'h00,8'h30,8'h22,8'h33,8'h44,8'h40,1'b1,8'h00,8'h00, 8'h30,8'hF2,8'h33,8'h44,8'h40,8'h0D,1'b0,1'b0,8'h00,8'h00};
    vecs[5]  = '{8'h0A,8'h88,8'h45,8'h11,8'h22,8'h33,8'h44,8'h40,1'b1,8'h05,8'h9D, 8'h11,8'h22,8'h9D,8'h44,8'h40,8'h0C,1'b1,1'b0,8'h00,8'h00};
    vecs[6]  = '{8'h14,8'h9C,8'h30,8'h11,8'h22,8'h33,8'h07,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h07,8'h40,8'h16,1'b0,1'b1,8'h30,8'h07};
    vecs[7]  = '{8'h00,8'hA0,8'h00,8'hA5,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'hA5,8'h22,8'h33,8'h44,8'h3F,8'h01,1'b0,1'b1,8'h3F,8'hA5};
    vecs[8]  = '{8'h00,8'hA4,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'hFF,8'h01,1'b0,1'b1,8'h3F,8'h22};
    vecs[9]  = '{8'h1E,8'hB8,8'h00,8'h11,8'h22,8'h33,8'h44,8'h3F,1'b0,8'h3F,8'hA5, 8'h11,8'h22,8'hA5,8'h44,8'h40,8'h1F,1'b0,1'b0,8'h00,8'h00};
    vecs[10] = '{8'h28,8'hBC,8'h00,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h5E, 8'h11,8'h22,8'h33,8'h5E,8'h41,8'h29,1'b0,1'b0,8'h00,8'h00};
    vecs[11] = '{8'h14,8'hD0,8'hF0,8'h11,8'h22,8'h33,8'h44,8'h40,1'b1,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h06,1'b1,1'b0,8'h00,8'h00};
    vecs[12] = '{8'h14,8'hD0,8'hF0,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h16,1'b0,1'b0,8'h00,8'h00};
    vecs[13] = '{8'h0F,8'hE0,8'hF7,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h08,1'b0,1'b0,8'h00,8'h00};
    vecs[14] = '{8'hFE,8'hC0,8'h03,8'h11,8'h22,8'h33,8'h44,8'h40,1'b0,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h03,1'b0,1'b0,8'h00,8'h00};
    vecs[15] = '{8'hFF,8'h00,8'h00,8'h11,8'h22,8'h33,8'h44,8'h40,1'b1,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h00,1'b1,1'b0,8'h00,8'h00};
    vecs[16] = '{8'h11,8'hF0,8'h00,8'h11,8'h22,8'h33,8'h44,8'h40,1'b1,8'h00,8'h00, 8'h11,8'h22,8'h33,8'h44,8'h40,8'h11,1'b1,1'b0,8'h00,8'h00};

    clear_mem();
    set_regs(8'h11, 8'h22, 8'h33, 8'h44, 8'h20, 8'h05, 1'b1);

    // Reset state
    #2;
    chk("rst_halted", halted, 1'b0);
    chk("rst_wf", write_flag, 1'b0);
    chk("rst_next_a", next_a, 8'h00);
    chk("rst_next_d", next_d, 8'h00);
    chk("rst_next_sp", next_sp, 8'h40);
    chk("rst_next_ip", next_ip, 8'h00);
    chk("rst_next_zf", next_zf, 1'b0);
    RESET = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(posedge CLOCK);
      #1;
      clear_mem();
      mem[vecs[i].daddr[5:0]] = vecs[i].dval;
      mem[vecs[i].ip[5:0]]    = vecs[i].op;
      ipn = vecs[i].ip + 8'd1;
      mem[ipn[5:0]]           = vecs[i].imm;
      set_regs(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].sp, vecs[i].ip, vecs[i].zf);
      #1;
      tests++;
      if (next_a !== vecs[i].ea || next_b !== vecs[i].eb || next_c !== vecs[i].ec ||
          next_d !== vecs[i].ed || next_sp !== vecs[i].esp || next_ip !== vecs[i].eip ||
          next_zf !== vecs[i].ezf || write_flag !== vecs[i].ewf ||
          write_addr !== 64'(vecs[i].ewaddr) || write_value !== vecs[i].ewval) begin
        fails++;
        $display("FAIL vec%0d: got a=%h b=%h c=%h d=%h sp=%h ip=%h zf=%b wf=%b wa=%0h wv=%h, expected a=%h b=%h c=%h d=%h sp=%h ip=%h zf=%b wf=%b wa=%0h wv=%h",
                 i, next_a, next_b, next_c, next_d, next_sp, next_ip, next_zf, write_flag, write_addr, write_value,
                 vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed, vecs[i].esp, vecs[i].eip, vecs[i].ezf,
                 vecs[i].ewf, vecs[i].ewaddr, vecs[i].ewval);
      end
    end
    @(posedge CLOCK);
    #1;
    chk("hlt_sets_halted", halted, 1'b1);

    // add wraps to zero, then mov keeps zf
    pulse_reset();
    clear_mem();
    mem[0] = 8'h44; mem[1] = 8'hFF; mem[2] = 8'h54; mem[3] = 8'h01; mem[4] = 8'h40; mem[5] = 8'h07;
    set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 1'b0);
    step();
    step();
    chk("add_wrap_b", b, 8'h00);
    chk("add_wrap_zf", zf, 1'b1);
    step();
    chk("mov_a", a, 8'h07);
    chk("mov_keeps_zf", zf, 1'b1);

    // push a then pop c through the stack
    clear_mem();
    mem[0] = 8'hA0; mem[1] = 8'hB8;
    set_regs(8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 1'b0);
    @(negedge CLOCK);
    chk("push_wf", write_flag, 1'b1);
    chk("push_waddr", write_addr, 64'd63);
    chk("push_wval", write_value, 8'hA5);
    chk("push_sp", next_sp, 8'h3F);
    step();
    @(negedge CLOCK);
    chk("pop_c", next_c, 8'hA5);
    chk("pop_sp", next_sp, 8'h40);
    chk("pop_wf", write_flag, 1'b0);

    // st then ld through the same address
    clear_mem();
    mem[0] = 8'h9C; mem[1] = 8'h30; mem[2] = 8'h80; mem[3] = 8'h30;
    set_regs(8'h00, 8'h00, 8'h00, 8'h07, 8'h40, 8'h00, 1'b0);
    @(negedge CLOCK);
    chk("st_wf", write_flag, 1'b1);
    chk("st_waddr", write_addr, 64'd48);
    chk("st_wval", write_value, 8'h07);
    step();
    @(negedge CLOCK);
    chk("ld_a", next_a, 8'h07);
    chk("ld_ip", next_ip, 8'h04);

    // Fibonacci program run to hlt
    pulse_reset();
    clear_mem();
    mem[0]  = 8'h40; mem[1]  = 8'h01; mem[2]  = 8'h44; mem[3]  = 8'h01;
    mem[4]  = 8'h48; mem[5]  = 8'h00; mem[6]  = 8'h4C; mem[7]  = 8'h01;
    mem[8]  = 8'h09; mem[9]  = 8'h04; mem[10] = 8'h12; mem[11] = 8'h5C;
    mem[12] = 8'h01; mem[13] = 8'h7C; mem[14] = 8'h09; mem[15] = 8'hE0;
    mem[16] = 8'hF7; mem[17] = 8'hF0;
    set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 1'b0);
    n = 0;
    while (halted !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    chk("fib_halted", halted, 1'b1);
    chk("fib_a", a, 8'd55);
    chk("fib_b", b, 8'd34);
    chk("fib_c", c, 8'd21);
    chk("fib_d", d, 8'd9);
    chk("fib_zf", zf, 1'b1);
    chk("fib_ip", ip, 8'd17);

    // frozen while halted even if the instruction at ip changes
    mem[17] = 8'h40; mem[18] = 8'h00;
    @(negedge CLOCK);
    chk("frozen_a", next_a, 8'd55);
    chk("frozen_ip", next_ip, 8'd17);
    chk("frozen_wf", write_flag, 1'b0);

    // asynchronous reset while halted
    #2;
    RESET = 1'b1;
    #1;
    chk("rst_async_halted", halted, 1'b0);
    chk("rst_async_wf", write_flag, 1'b0);
    chk("rst_async_sp", next_sp, 8'h40);
    chk("rst_async_ip", next_ip, 8'h00);
    chk("rst_async_a", next_a, 8'h00);
    #1;
    RESET = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
